// File: rtl/counter_pkg.sv
// Shared definitions for the bounded count checker: FSM state encoding and
// the default bus widths used when the top is instantiated without overrides.
package counter_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_STAT_WIDTH = 16;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        CFG_ERR  = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the wrap and error statistics. It sticks at
// all-ones instead of rolling over, so a long error burst never reads as zero.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;
    logic             w_atMax;

    assign w_atMax = &r_count;
    assign count   = r_count;

    // Reset beats clear, clear beats increment; increments stop at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !w_atMax) begin
            r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/bounded_count_checker.sv
// Watches samples from a counter that runs lower_bound..upper_bound and wraps,
// locks onto the sequence, and flags any sample that breaks it. All outputs
// are registered, so they reflect the sample seen on the previous edge.
module bounded_count_checker
    import counter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int STAT_WIDTH = DEFAULT_STAT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0] lower_bound,
    input  logic [DATA_WIDTH-1:0] upper_bound,
    input  logic                  clear,
    output logic                  locked,
    output logic [DATA_WIDTH-1:0] expected,
    output logic                  err_pulse,
    output logic                  bad_cfg,
    output logic [STAT_WIDTH-1:0] wrap_count,
    output logic [STAT_WIDTH-1:0] err_count
);

    state_t                r_state;
    state_t                w_stateNext;
    logic [DATA_WIDTH-1:0] r_expected;
    logic [DATA_WIDTH-1:0] w_expectedNext;
    logic                  r_errPulse;
    logic                  w_errNext;
    logic                  r_badCfg;
    logic                  w_cfgBad;
    logic                  w_inRange;
    logic                  w_match;
    logic [DATA_WIDTH-1:0] w_successor;
    logic                  w_errInc;
    logic                  w_wrapInc;

    assign w_cfgBad  = lower_bound > upper_bound;
    assign w_inRange = (in_data >= lower_bound) && (in_data <= upper_bound);
    assign w_match   = in_data == r_expected;

    // The counter's own successor rule: wrap to the low bound at the top,
    // otherwise step by one. Only used for in-range samples, so no overflow.
    assign w_successor = (in_data == upper_bound)
                       ? lower_bound
                       : in_data + {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    // Next-state and per-sample decisions. A bad configuration wins over
    // everything, and leaving CFG_ERR spends one cycle ignoring samples.
    always_comb begin
        w_stateNext    = r_state;
        w_expectedNext = r_expected;
        w_errNext      = 1'b0;
        w_errInc       = 1'b0;
        w_wrapInc      = 1'b0;
        if (w_cfgBad) begin
            w_stateNext = CFG_ERR;
        end else if (r_state == CFG_ERR) begin
            w_stateNext = UNLOCKED;
        end else if (clear) begin
            w_stateNext = UNLOCKED;
        end else if (in_valid) begin
            case (r_state)
                UNLOCKED: begin
                    if (w_inRange) begin
                        w_expectedNext = w_successor;
                        w_stateNext    = LOCKED;
                    end else begin
                        w_errNext = 1'b1;
                        w_errInc  = 1'b1;
                    end
                end
                LOCKED: begin
                    if (!w_inRange) begin
                        w_errNext   = 1'b1;
                        w_errInc    = 1'b1;
                        w_stateNext = UNLOCKED;
                    end else if (w_match) begin
                        w_expectedNext = w_successor;
                        w_wrapInc      = in_data == upper_bound;
                    end else begin
                        w_errNext      = 1'b1;
                        w_errInc       = 1'b1;
                        w_expectedNext = w_successor;
                    end
                end
                default: begin
                    w_stateNext = UNLOCKED;
                end
            endcase
        end
    end

    // State, expected value and the one-cycle error / config flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= UNLOCKED;
            r_expected <= '0;
            r_errPulse <= 1'b0;
            r_badCfg   <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_expected <= w_expectedNext;
            r_errPulse <= w_errNext;
            r_badCfg   <= w_cfgBad;
        end
    end

    sat_counter #(.WIDTH(STAT_WIDTH)) u_wrapCounter (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (w_wrapInc),
        .count (wrap_count)
    );

    sat_counter #(.WIDTH(STAT_WIDTH)) u_errCounter (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (w_errInc),
        .count (err_count)
    );

    assign locked    = r_state == LOCKED;
    assign expected  = r_expected;
    assign err_pulse = r_errPulse;
    assign bad_cfg   = r_badCfg;

endmodule

// File: tb/tb_bounded_count_checker.sv
// Bench for bounded_count_checker: directed scenarios plus a randomized run
// compared against a sample-by-sample behavioural model of the checker.
module tb_bounded_count_checker;

    localparam int DW      = 8;
    localparam int SW      = 2;
    localparam int STATMAX = (1 << SW) - 1;

    logic          clk;
    logic          rst;
    logic          inValid;
    logic [DW-1:0] inData;
    logic [DW-1:0] lowerBound;
    logic [DW-1:0] upperBound;
    logic          clear;
    logic          locked;
    logic [DW-1:0] expected;
    logic          errPulse;
    logic          badCfg;
    logic [SW-1:0] wrapCount;
    logic [SW-1:0] errCount;

    int checkCount = 0;
    int errorCount = 0;

    // Behavioural model state
    bit mLocked;
    bit mBad;
    bit mErr;
    int mExp;
    int mWrap;
    int mErrCnt;

    bounded_count_checker #(.DATA_WIDTH(DW), .STAT_WIDTH(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (inValid),
        .in_data     (inData),
        .lower_bound (lowerBound),
        .upper_bound (upperBound),
        .clear       (clear),
        .locked      (locked),
        .expected    (expected),
        .err_pulse   (errPulse),
        .bad_cfg     (badCfg),
        .wrap_count  (wrapCount),
        .err_count   (errCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: what one clock edge does to the checker given the current inputs
    task automatic modelUpdate();
        int lb;
        int ub;
        int d;
        bit inR;
        lb = int'(lowerBound);
        ub = int'(upperBound);
        d  = int'(inData);
        mErr = 1'b0;
        if (!rst) begin
            mLocked = 0; mBad = 0; mExp = 0; mWrap = 0; mErrCnt = 0;
        end else begin
            if (clear) begin
                mWrap = 0; mErrCnt = 0;
            end
            if (lb > ub) begin
                mBad = 1; mLocked = 0;
            end else if (mBad) begin
                mBad = 0; mLocked = 0;
            end else if (clear) begin
                mLocked = 0;
            end else if (inValid) begin
                inR = (d >= lb) && (d <= ub);
                if (!inR) begin
                    mErr = 1;
                    mErrCnt = (mErrCnt < STATMAX) ? mErrCnt + 1 : STATMAX;
                    mLocked = 0;
                end else begin
                    if (mLocked && d == mExp) begin
                        if (d == ub) mWrap = (mWrap < STATMAX) ? mWrap + 1 : STATMAX;
                    end else if (mLocked) begin
                        mErr = 1;
                        mErrCnt = (mErrCnt < STATMAX) ? mErrCnt + 1 : STATMAX;
                    end
                    mExp = (d == ub) ? lb : d + 1;
                    mLocked = 1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, and sample 1 ns past the edge
    task automatic applyStimulus(input bit v, input int d, input bit c);
        inValid = v;
        inData  = DW'(d);
        clear   = c;
        modelUpdate();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        lowerBound = 8'd3;
        upperBound = 8'd10;
        doReset();
        checkCount++;
        if (locked !== 1'b0 || expected !== 8'd0 || errPulse !== 1'b0 || badCfg !== 1'b0 ||
            wrapCount !== 2'd0 || errCount !== 2'd0) begin
            errorCount++;
            $display("FAIL reset_state got lk=%b exp=%0d ep=%b bc=%b wc=%0d ec=%0d want all zero",
                     locked, expected, errPulse, badCfg, wrapCount, errCount);
        end
    endtask

    task automatic test_clean_sequence();
        doReset();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, 3 + (i % 8), 0);
            checkCount++;
            if (locked !== 1'b1 || errPulse !== 1'b0) begin
                errorCount++;
                $display("FAIL clean_locked step %0d got lk=%b ep=%b want lk=1 ep=0", i, locked, errPulse);
            end
        end
        checkCount++;
        if (errCount !== 2'd0 || wrapCount !== 2'd2 || expected !== 8'd4) begin
            errorCount++;
            $display("FAIL clean_end got ec=%0d wc=%0d exp=%0d want ec=0 wc=2 exp=4",
                     errCount, wrapCount, expected);
        end
    endtask

    task automatic test_mismatch();
        doReset();
        applyStimulus(1, 5, 0);
        applyStimulus(1, 7, 0);
        checkCount++;
        if (errPulse !== 1'b1 || errCount !== 2'd1 || expected !== 8'd8 || locked !== 1'b1) begin
            errorCount++;
            $display("FAIL mismatch got ep=%b ec=%0d exp=%0d lk=%b want ep=1 ec=1 exp=8 lk=1",
                     errPulse, errCount, expected, locked);
        end
        applyStimulus(0, 0, 0);
        checkCount++;
        if (errPulse !== 1'b0 || errCount !== 2'd1) begin
            errorCount++;
            $display("FAIL mismatch_one_cycle got ep=%b ec=%0d want ep=0 ec=1", errPulse, errCount);
        end
    endtask

    task automatic test_out_of_range();
        doReset();
        applyStimulus(1, 5, 0);
        applyStimulus(1, 12, 0);
        checkCount++;
        if (errPulse !== 1'b1 || errCount !== 2'd1 || locked !== 1'b0) begin
            errorCount++;
            $display("FAIL out_of_range got ep=%b ec=%0d lk=%b want ep=1 ec=1 lk=0",
                     errPulse, errCount, locked);
        end
        applyStimulus(1, 4, 0);
        checkCount++;
        if (locked !== 1'b1 || expected !== 8'd5 || errPulse !== 1'b0) begin
            errorCount++;
            $display("FAIL reacquire got lk=%b exp=%0d ep=%b want lk=1 exp=5 ep=0",
                     locked, expected, errPulse);
        end
    endtask

    task automatic test_bad_cfg();
        doReset();
        applyStimulus(1, 5, 0);
        lowerBound = 8'd10;
        upperBound = 8'd3;
        applyStimulus(1, 5, 0);
        checkCount++;
        if (badCfg !== 1'b1 || locked !== 1'b0 || errPulse !== 1'b0 || expected !== 8'd6) begin
            errorCount++;
            $display("FAIL bad_cfg got bc=%b lk=%b ep=%b exp=%0d want bc=1 lk=0 ep=0 exp=6",
                     badCfg, locked, errPulse, expected);
        end
        applyStimulus(1, 200, 0);
        checkCount++;
        if (errPulse !== 1'b0 || errCount !== 2'd0) begin
            errorCount++;
            $display("FAIL bad_cfg_ignore got ep=%b ec=%0d want ep=0 ec=0", errPulse, errCount);
        end
        lowerBound = 8'd3;
        upperBound = 8'd10;
        applyStimulus(0, 0, 0);
        checkCount++;
        if (badCfg !== 1'b0 || locked !== 1'b0) begin
            errorCount++;
            $display("FAIL cfg_restore got bc=%b lk=%b want bc=0 lk=0", badCfg, locked);
        end
        applyStimulus(1, 4, 0);
        checkCount++;
        if (locked !== 1'b1 || expected !== 8'd5 || errPulse !== 1'b0) begin
            errorCount++;
            $display("FAIL cfg_relock got lk=%b exp=%0d ep=%b want lk=1 exp=5 ep=0",
                     locked, expected, errPulse);
        end
    endtask

    task automatic test_reset_clear();
        doReset();
        for (int v = 3; v <= 8; v++) applyStimulus(1, v, 0);
        rst = 1'b0;
        applyStimulus(1, 9, 1);
        rst = 1'b1;
        checkCount++;
        if (locked !== 1'b0 || expected !== 8'd0 || errPulse !== 1'b0 || badCfg !== 1'b0 ||
            wrapCount !== 2'd0 || errCount !== 2'd0) begin
            errorCount++;
            $display("FAIL mid_reset got lk=%b exp=%0d ep=%b bc=%b wc=%0d ec=%0d want all zero",
                     locked, expected, errPulse, badCfg, wrapCount, errCount);
        end
        applyStimulus(1, 6, 0);
        checkCount++;
        if (locked !== 1'b1 || expected !== 8'd7 || errPulse !== 1'b0) begin
            errorCount++;
            $display("FAIL reset_reacquire got lk=%b exp=%0d ep=%b want lk=1 exp=7 ep=0",
                     locked, expected, errPulse);
        end
        applyStimulus(1, 9, 0);
        applyStimulus(1, 5, 1);
        checkCount++;
        if (locked !== 1'b0 || errPulse !== 1'b0 || errCount !== 2'd0 || expected !== 8'd10) begin
            errorCount++;
            $display("FAIL clear_priority got lk=%b ep=%b ec=%0d exp=%0d want lk=0 ep=0 ec=0 exp=10",
                     locked, errPulse, errCount, expected);
        end
        applyStimulus(1, 8, 0);
        checkCount++;
        if (locked !== 1'b1 || expected !== 8'd9 || errPulse !== 1'b0) begin
            errorCount++;
            $display("FAIL clear_reacquire got lk=%b exp=%0d ep=%b want lk=1 exp=9 ep=0",
                     locked, expected, errPulse);
        end
    endtask

    task automatic test_saturation();
        int want;
        doReset();
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1, 200, 0);
            want = (k < 3) ? k : 3;
            checkCount++;
            if (errCount !== SW'(want) || errPulse !== 1'b1) begin
                errorCount++;
                $display("FAIL err_saturate k=%0d got ec=%0d ep=%b want ec=%0d ep=1",
                         k, errCount, errPulse, want);
            end
        end
        lowerBound = 8'd5;
        upperBound = 8'd5;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1, 5, 0);
            want = (k < 3) ? k : 3;
            checkCount++;
            if (wrapCount !== SW'(want) || errPulse !== 1'b0 || expected !== 8'd5) begin
                errorCount++;
                $display("FAIL wrap_equal_bounds k=%0d got wc=%0d ep=%b exp=%0d want wc=%0d ep=0 exp=5",
                         k, wrapCount, errPulse, expected, want);
            end
        end
    endtask

    task automatic test_random();
        int d;
        int lb;
        int ub;
        lowerBound = 8'd3;
        upperBound = 8'd10;
        doReset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 19) == 0) begin
                lb = $urandom_range(0, 20);
                ub = lb + $urandom_range(0, 15);
                if ($urandom_range(0, 4) == 0 && lb > 0) begin
                    lowerBound = DW'(ub);
                    upperBound = DW'(lb - 1);
                end else begin
                    lowerBound = DW'(lb);
                    upperBound = DW'(ub);
                end
            end
            if (mLocked && $urandom_range(0, 3) != 0) d = mExp;
            else d = $urandom_range(0, 40);
            rst = ($urandom_range(0, 49) != 0);
            applyStimulus($urandom_range(0, 9) < 7, d, $urandom_range(0, 29) == 0);
            rst = 1'b1;
            checkCount++;
            if (locked !== mLocked || expected !== DW'(mExp) || errPulse !== mErr ||
                badCfg !== mBad || wrapCount !== SW'(mWrap) || errCount !== SW'(mErrCnt)) begin
                errorCount++;
                $display("FAIL random cycle %0d got lk=%b exp=%0d ep=%b bc=%b wc=%0d ec=%0d want lk=%b exp=%0d ep=%b bc=%b wc=%0d ec=%0d",
                         cyc, locked, expected, errPulse, badCfg, wrapCount, errCount,
                         mLocked, mExp, mErr, mBad, mWrap, mErrCnt);
            end
        end
    endtask

    initial begin
        rst        = 1'b0;
        inValid    = 1'b0;
        inData     = '0;
        clear      = 1'b0;
        lowerBound = 8'd3;
        upperBound = 8'd10;
        mLocked = 0; mBad = 0; mErr = 0; mExp = 0; mWrap = 0; mErrCnt = 0;
        test_reset();
        test_clean_sequence();
        test_mismatch();
        test_out_of_range();
        test_bad_cfg();
        test_reset_clear();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
